// File: rtl/i2c_target.sv
// ----------------------------------------------------------------------------
// i2c_target
//
// I2C target (slave) responder with a fixed 7-bit address. It is the far end
// of the bus driven by the I2C master core, so the master can be looped back
// on-board, or the FPGA can act as a bus peripheral.
// 7-bit addressing only, no clock stretching, no general call.
//
// Ports
//   clk        system clock, at least 16x the SCL rate
//   reset      synchronous, active-high reset
//   scl        bus clock (input only, never driven)
//   sda        open-drain data: pulled low when the target drives 0, else 'z
//   rx_data    last byte written by the master, held until the next byte
//   rx_valid   one-clk pulse, rx_data has just been updated
//   tx_req     one-clk pulse, the fabric must present the next read byte
//   tx_data    read byte, sampled at the SCL fall that starts the byte
//   busy       high from address match until STOP, repeated START or reset
//   nack_rcvd  one-clk pulse, the master NACKed a read byte
// ----------------------------------------------------------------------------
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  tri         sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       nack_rcvd
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_t;

    state_t     state;
    logic [2:0] bitcnt;
    logic [7:0] shift;
    logic       rw;
    logic       byte_done;
    logic       ack_ok;
    logic       sda_oe;

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // Open-drain output: only ever pull low, otherwise release the line.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Two-flop synchronisers plus one history flop per line. They reset to
    // the idle bus level so leaving reset never fakes a START or STOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    // SCL must be high on both the current and the previous synced sample, so
    // an SDA change that lands on the same clk as an SCL fall is ordinary data.
    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 &  scl_h;
    assign start_det =  scl_s2 &  scl_h &  sda_h & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_h & ~sda_h &  sda_s2;

    // Protocol FSM. byte_done marks "8th bit sampled, waiting for the SCL fall
    // that opens the ACK clock"; ack_ok marks "master ACKed a read byte,
    // waiting for the fall that starts the next one".
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            shift     <= 8'h00;
            rw        <= 1'b0;
            byte_done <= 1'b0;
            ack_ok    <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            nack_rcvd <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            nack_rcvd <= 1'b0;

            if (start_det) begin
                // START or repeated START: any partial byte is discarded.
                state     <= ADDR;
                bitcnt    <= 3'd0;
                shift     <= 8'h00;
                byte_done <= 1'b0;
                ack_ok    <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                byte_done <= 1'b0;
                ack_ok    <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        sda_oe <= 1'b0;
                    end

                    ADDR: begin
                        if (scl_rise && !byte_done) begin
                            shift  <= {shift[6:0], sda_s2};
                            bitcnt <= bitcnt + 3'd1;
                            // On the 8th rise shift[6:0] holds the address
                            // bits and the live sample is the R/W bit.
                            if (bitcnt == 3'd7) begin
                                if (shift[6:0] == DEV_ADDR) begin
                                    busy      <= 1'b1;
                                    rw        <= sda_s2;
                                    tx_req    <= sda_s2;
                                    byte_done <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= ADDR_ACK;
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bitcnt <= 3'd0;
                            if (rw) begin
                                shift  <= tx_data;
                                sda_oe <= ~tx_data[7];
                                state  <= RD_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_BYTE;
                            end
                        end
                    end

                    WR_BYTE: begin
                        if (scl_rise && !byte_done) begin
                            shift  <= {shift[6:0], sda_s2};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) begin
                                rx_data   <= {shift[6:0], sda_s2};
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= WR_ACK;
                        end
                    end

                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            bitcnt <= 3'd0;
                            state  <= WR_BYTE;
                        end
                    end

                    RD_BYTE: begin
                        // Rotating keeps the next bit to drive in shift[7];
                        // the fall after bit 0 hands the line to the master.
                        if (scl_fall) begin
                            if (bitcnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                bitcnt <= 3'd0;
                                state  <= RD_ACK;
                            end else begin
                                shift  <= {shift[6:0], shift[7]};
                                sda_oe <= ~shift[6];
                                bitcnt <= bitcnt + 3'd1;
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise && !ack_ok) begin
                            if (!sda_s2) begin
                                tx_req <= 1'b1;
                                ack_ok <= 1'b1;
                            end else begin
                                nack_rcvd <= 1'b1;
                                state     <= WAIT_STOP;
                            end
                        end else if (scl_fall && ack_ok) begin
                            ack_ok <= 1'b0;
                            shift  <= tx_data;
                            sda_oe <= ~tx_data[7];
                            bitcnt <= 3'd0;
                            state  <= RD_BYTE;
                        end
                    end

                    WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        sda_oe <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// ----------------------------------------------------------------------------
// tb_i2c_target
//
// Bit-banged I2C master driving i2c_target over an open-drain SDA line with
// a pull-up. Written bytes and read bytes are pushed to expectation queues
// when driven and popped when the DUT delivers them.
// ----------------------------------------------------------------------------
module tb_i2c_target;

    // SCL quarter period in clk cycles (SCL period = 32 clks).
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       m_sda_low;
    wire        sda_bus;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       busy;
    logic       nack_rcvd;

    pullup (sda_bus);
    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target #(.DEV_ADDR(7'h42)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl_m),
        .sda       (sda_bus),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .busy      (busy),
        .nack_rcvd (nack_rcvd)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    int cnt_rx      = 0;
    int cnt_txreq   = 0;
    int cnt_nack    = 0;
    int dut_low_cnt = 0;
    bit busy_seen   = 1'b0;

    logic [7:0] exp_rx[$];
    logic [7:0] tx_src[$];
    logic [7:0] exp_rd[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor and fabric model, sampled 1 time unit after the falling edge.
    always begin
        @(negedge clk);
        #1;
        if (rx_valid) begin
            cnt_rx++;
            if (exp_rx.size() == 0)
                checkOutput("rx_pulse_expected", 32'(exp_rx.size()), 32'd1);
            else
                checkOutput("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
        end
        if (tx_req) begin
            cnt_txreq++;
            if (tx_src.size() > 0) tx_data = tx_src.pop_front();
        end
        if (nack_rcvd) cnt_nack++;
        if (busy) busy_seen = 1'b1;
        if (!m_sda_low && sda_bus === 1'b0) dut_low_cnt++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        wait_clks(Q);
        m_sda_low = ~b;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(2 * Q);
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clks(Q);
        m_sda_low = 1'b0;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        b = sda_bus;
        wait_clks(Q);
        scl_m = 1'b0;
    endtask

    task automatic start_cond();
        wait_clks(Q);
        m_sda_low = 1'b0;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        m_sda_low = 1'b1;
        wait_clks(Q);
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clks(Q);
        m_sda_low = 1'b1;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        m_sda_low = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input bit expect_rx,
                              output logic ack);
        if (expect_rx) exp_rx.push_back(d);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic send_nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(send_nack);
    endtask

    // One scenario per call.
    task automatic applyStimulus(input int test_no);
        logic       ack;
        logic [7:0] d;
        int         base_rx, base_tx, base_nack;
        base_rx   = cnt_rx;
        base_tx   = cnt_txreq;
        base_nack = cnt_nack;
        case (test_no)
            1: begin
                start_cond();
                write_byte(8'h84, 1'b0, ack);
                checkOutput("t1_addr_ack", {31'd0, ack}, 32'd0);
                checkOutput("t1_busy_after_match", {31'd0, busy}, 32'd1);
                write_byte(8'hA5, 1'b1, ack);
                checkOutput("t1_data1_ack", {31'd0, ack}, 32'd0);
                write_byte(8'h3C, 1'b1, ack);
                checkOutput("t1_data2_ack", {31'd0, ack}, 32'd0);
                checkOutput("t1_busy_before_stop", {31'd0, busy}, 32'd1);
                stop_cond();
                wait_clks(4);
                checkOutput("t1_busy_after_stop", {31'd0, busy}, 32'd0);
                checkOutput("t1_rx_count", 32'(cnt_rx - base_rx), 32'd2);
                checkOutput("t1_rx_leftover", 32'(exp_rx.size()), 32'd0);
            end
            2: begin
                tx_src.push_back(8'h5A);
                tx_src.push_back(8'hC3);
                exp_rd.push_back(8'h5A);
                exp_rd.push_back(8'hC3);
                start_cond();
                write_byte(8'h85, 1'b0, ack);
                checkOutput("t2_addr_ack", {31'd0, ack}, 32'd0);
                read_byte(1'b0, d);
                checkOutput("t2_read1", {24'd0, d}, {24'd0, exp_rd.pop_front()});
                read_byte(1'b1, d);
                checkOutput("t2_read2", {24'd0, d}, {24'd0, exp_rd.pop_front()});
                wait_clks(Q);
                checkOutput("t2_wait_stop_released", {31'd0, sda_bus}, 32'd1);
                stop_cond();
                wait_clks(4);
                checkOutput("t2_tx_req_count", 32'(cnt_txreq - base_tx), 32'd2);
                checkOutput("t2_nack_count", 32'(cnt_nack - base_nack), 32'd1);
                checkOutput("t2_busy_after_stop", {31'd0, busy}, 32'd0);
            end
            3: begin
                dut_low_cnt = 0;
                busy_seen   = 1'b0;
                start_cond();
                write_byte(8'h86, 1'b0, ack);
                checkOutput("t3_addr_nack", {31'd0, ack}, 32'd1);
                write_byte(8'h11, 1'b0, ack);
                checkOutput("t3_data_nack", {31'd0, ack}, 32'd1);
                stop_cond();
                wait_clks(4);
                checkOutput("t3_sda_never_low", 32'(dut_low_cnt), 32'd0);
                checkOutput("t3_rx_count", 32'(cnt_rx - base_rx), 32'd0);
                checkOutput("t3_tx_req_count", 32'(cnt_txreq - base_tx), 32'd0);
                checkOutput("t3_busy_seen", {31'd0, busy_seen}, 32'd0);
            end
            4: begin
                start_cond();
                write_byte(8'h84, 1'b0, ack);
                checkOutput("t4_addr_w_ack", {31'd0, ack}, 32'd0);
                write_byte(8'h07, 1'b1, ack);
                checkOutput("t4_data_ack", {31'd0, ack}, 32'd0);
                checkOutput("t4_busy_before_sr", {31'd0, busy}, 32'd1);
                start_cond();
                checkOutput("t4_busy_after_sr", {31'd0, busy}, 32'd0);
                tx_src.push_back(8'h99);
                exp_rd.push_back(8'h99);
                write_byte(8'h85, 1'b0, ack);
                checkOutput("t4_addr_r_ack", {31'd0, ack}, 32'd0);
                checkOutput("t4_busy_rerise", {31'd0, busy}, 32'd1);
                read_byte(1'b1, d);
                checkOutput("t4_read", {24'd0, d}, {24'd0, exp_rd.pop_front()});
                stop_cond();
                wait_clks(4);
                checkOutput("t4_rx_data_held", {24'd0, rx_data}, 32'h07);
                checkOutput("t4_nack_count", 32'(cnt_nack - base_nack), 32'd1);
            end
            5: begin
                tx_src.push_back(8'h12);
                start_cond();
                write_byte(8'h85, 1'b0, ack);
                checkOutput("t5_addr_ack", {31'd0, ack}, 32'd0);
                wait_clks(Q);
                checkOutput("t5_target_drives_0", {31'd0, sda_bus}, 32'd0);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                checkOutput("t5_released_after_reset", {31'd0, sda_bus}, 32'd1);
                checkOutput("t5_busy_after_reset", {31'd0, busy}, 32'd0);
                checkOutput("t5_rx_data_after_reset", {24'd0, rx_data}, 32'd0);
                dut_low_cnt = 0;
                base_tx     = cnt_txreq;
                read_byte(1'b1, d);
                stop_cond();
                wait_clks(4);
                checkOutput("t5_ignored_bus", 32'(dut_low_cnt), 32'd0);
                checkOutput("t5_no_tx_req_after_reset", 32'(cnt_txreq - base_tx), 32'd0);
                start_cond();
                write_byte(8'h84, 1'b0, ack);
                checkOutput("t5_new_addr_ack", {31'd0, ack}, 32'd0);
                write_byte(8'h55, 1'b1, ack);
                checkOutput("t5_new_data_ack", {31'd0, ack}, 32'd0);
                stop_cond();
                wait_clks(4);
                checkOutput("t5_rx_data", {24'd0, rx_data}, 32'h55);
            end
            6: begin
                start_cond();
                write_byte(8'h84, 1'b0, ack);
                checkOutput("t6_addr_ack", {31'd0, ack}, 32'd0);
                wait_clks(Q);
                dut_low_cnt = 0;
                base_rx     = cnt_rx;
                write_bit(1'b1);
                write_bit(1'b0);
                write_bit(1'b1);
                write_bit(1'b1);
                stop_cond();
                wait_clks(4);
                checkOutput("t6_busy_after_stop", {31'd0, busy}, 32'd0);
                // Further clocks without a START must get no response.
                for (int i = 0; i < 9; i++) read_bit(ack);
                checkOutput("t6_no_ack_driven", 32'(dut_low_cnt), 32'd0);
                checkOutput("t6_rx_count", 32'(cnt_rx - base_rx), 32'd0);
            end
            default: ;
        endcase
    endtask

    initial begin
        reset     = 1'b1;
        scl_m     = 1'b1;
        m_sda_low = 1'b0;
        tx_data   = 8'h00;
        wait_clks(5);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_tx_req", {31'd0, tx_req}, 32'd0);
        checkOutput("reset_nack", {31'd0, nack_rcvd}, 32'd0);
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_sda", {31'd0, sda_bus}, 32'd1);
        reset = 1'b0;
        wait_clks(5);

        for (int t = 1; t <= 6; t++) begin
            applyStimulus(t);
            wait_clks(2 * Q);
        end

        checkOutput("end_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
        checkOutput("end_tx_queue_empty", 32'(tx_src.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
